dp_ram_be: RTL and testbench

DP_RAM_BE -- requirements
Module: dp_ram_be

---
 rtl/dp_ram_be.sv | 224 ++++++++++++++++++++++
 tb/tb_dp_ram_be.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_ram_be.sv
// dp_ram_be: true dual-port RAM with per-byte write enables and a
// background clear engine.
//
// Ports
//   clk, rst            clock and asynchronous active-high reset
//   clr / busy          start a whole-array clear / clear in progress
//   req_x, we_x, be_x   per-port request, write select, byte enables
//   addr_x, wd_x        byte address, write data
//   rd_x, rvalid_x      read data (held between reads), read-valid pulse
//   err_x               rejected (busy) or out-of-range request
//   collision           both ports hit the same word and at least one wrote
//
// Responses appear 1 + OUT_REG cycles after the request edge.
// A same-port write also loads rd_x (old word, or the byte-merged new word
// when RDW_FIRST=1) without pulsing rvalid_x.
module dp_ram_be #(
    parameter int DATA_W     = 32,
    parameter int WORD_COUNT = 256,
    parameter int ADDR_W     = 32,
    parameter int OUT_REG    = 0,
    parameter int RDW_FIRST  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    output logic                  busy,
    input  logic                  req_a,
    input  logic                  we_a,
    input  logic [DATA_W/8-1:0]   be_a,
    input  logic [ADDR_W-1:0]     addr_a,
    input  logic [DATA_W-1:0]     wd_a,
    output logic [DATA_W-1:0]     rd_a,
    output logic                  rvalid_a,
    output logic                  err_a,
    input  logic                  req_b,
    input  logic                  we_b,
    input  logic [DATA_W/8-1:0]   be_b,
    input  logic [ADDR_W-1:0]     addr_b,
    input  logic [DATA_W-1:0]     wd_b,
    output logic [DATA_W-1:0]     rd_b,
    output logic                  rvalid_b,
    output logic                  err_b,
    output logic                  collision
);
    localparam int NB  = DATA_W / 8;
    localparam int BSH = $clog2(NB);
    localparam int IW  = ADDR_W - BSH;
    localparam int CW  = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // Memory content is not reset; it powers up as zero.
    logic [DATA_W-1:0] mem_q [WORD_COUNT] = '{default: '0};

    function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                      input logic [DATA_W-1:0] new_w,
                                                      input logic [NB-1:0]     be);
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

    logic [IW-1:0]     idx_a, idx_b;
    logic [CW-1:0]     wa_a, wa_b;
    logic              idle, inr_a, inr_b, act_a, act_b, wr_a, wr_b, same_w;
    logic [DATA_W-1:0] old_a, old_b, own_a, own_b, new_a;

    assign idx_a  = addr_a[ADDR_W-1:BSH];
    assign idx_b  = addr_b[ADDR_W-1:BSH];
    assign inr_a  = (idx_a < IW'(WORD_COUNT));
    assign inr_b  = (idx_b < IW'(WORD_COUNT));
    assign wa_a   = idx_a[CW-1:0];
    assign wa_b   = idx_b[CW-1:0];
    assign idle   = (state_q == S_IDLE);
    assign act_a  = req_a & idle;
    assign act_b  = req_b & idle;
    assign wr_a   = act_a & we_a & inr_a;
    assign wr_b   = act_b & we_b & inr_b;
    assign same_w = inr_a & inr_b & (idx_a == idx_b);
    assign old_a  = mem_q[wa_a];
    assign old_b  = mem_q[wa_b];
    assign own_a  = merge_bytes(old_a, wd_a, be_a);
    assign own_b  = merge_bytes(old_b, wd_b, be_b);
    // On a shared word A is layered over B so A wins the bytes both enabled.
    assign new_a  = (wr_b & same_w) ? merge_bytes(own_b, wd_a, be_a) : own_a;

    generate
        if (BSH > 0) begin : g_low_bits
            logic unused_low;
            assign unused_low = ^{addr_a[BSH-1:0], addr_b[BSH-1:0]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) mem_q[cnt_q] <= '0;
        if (wr_b) mem_q[wa_b] <= own_b;
        if (wr_a) mem_q[wa_a] <= new_a;
    end

    // Clear FSM
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (clr) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            S_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WORD_COUNT - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == S_CLEAR);

    // First response stage
    logic [DATA_W-1:0] rd_a_s1_q, rd_a_s1_d, rd_b_s1_q, rd_b_s1_d;
    logic              rv_a_s1_q, rv_a_s1_d, rv_b_s1_q, rv_b_s1_d;
    logic              er_a_s1_q, er_a_s1_d, er_b_s1_q, er_b_s1_d;
    logic              col_s1_q, col_s1_d;

    always_comb begin
        rd_a_s1_d = rd_a_s1_q;
        rd_b_s1_d = rd_b_s1_q;
        rv_a_s1_d = act_a & ~we_a;
        rv_b_s1_d = act_b & ~we_b;
        er_a_s1_d = req_a & (~idle | ~inr_a);
        er_b_s1_d = req_b & (~idle | ~inr_b);
        col_s1_d  = act_a & act_b & same_w & (we_a | we_b);
        if (act_a & ~we_a)  rd_a_s1_d = inr_a ? old_a : '0;
        else if (wr_a)      rd_a_s1_d = (RDW_FIRST != 0) ? own_a : old_a;
        if (act_b & ~we_b)  rd_b_s1_d = inr_b ? old_b : '0;
        else if (wr_b)      rd_b_s1_d = (RDW_FIRST != 0) ? own_b : old_b;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_a_s1_q <= '0;
            rd_b_s1_q <= '0;
            rv_a_s1_q <= 1'b0;
            rv_b_s1_q <= 1'b0;
            er_a_s1_q <= 1'b0;
            er_b_s1_q <= 1'b0;
            col_s1_q  <= 1'b0;
        end else begin
            rd_a_s1_q <= rd_a_s1_d;
            rd_b_s1_q <= rd_b_s1_d;
            rv_a_s1_q <= rv_a_s1_d;
            rv_b_s1_q <= rv_b_s1_d;
            er_a_s1_q <= er_a_s1_d;
            er_b_s1_q <= er_b_s1_d;
            col_s1_q  <= col_s1_d;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] rd_a_q, rd_b_q;
            logic              rv_a_q, rv_b_q, er_a_q, er_b_q, col_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_a_q <= '0;
                    rd_b_q <= '0;
                    rv_a_q <= 1'b0;
                    rv_b_q <= 1'b0;
                    er_a_q <= 1'b0;
                    er_b_q <= 1'b0;
                    col_q  <= 1'b0;
                end else begin
                    rd_a_q <= rd_a_s1_q;
                    rd_b_q <= rd_b_s1_q;
                    rv_a_q <= rv_a_s1_q;
                    rv_b_q <= rv_b_s1_q;
                    er_a_q <= er_a_s1_q;
                    er_b_q <= er_b_s1_q;
                    col_q  <= col_s1_q;
                end
            end
            assign rd_a      = rd_a_q;
            assign rd_b      = rd_b_q;
            assign rvalid_a  = rv_a_q;
            assign rvalid_b  = rv_b_q;
            assign err_a     = er_a_q;
            assign err_b     = er_b_q;
            assign collision = col_q;
        end else begin : g_no_out_reg
            assign rd_a      = rd_a_s1_q;
            assign rd_b      = rd_b_s1_q;
            assign rvalid_a  = rv_a_s1_q;
            assign rvalid_b  = rv_b_s1_q;
            assign err_a     = er_a_s1_q;
            assign err_b     = er_b_s1_q;
            assign collision = col_s1_q;
        end
    endgenerate

endmodule

// File: tb/tb_dp_ram_be.sv
// Testbench for dp_ram_be: two instances share one stimulus stream.
// u0 uses the defaults (latency 1, old-data RDW), u1 uses OUT_REG=1 and
// RDW_FIRST=1 (latency 2, new-data RDW). A word-array model predicts both.
module tb_dp_ram_be;
    logic        clk = 1'b0;
    logic        rst, clr;
    logic        req_a, we_a, req_b, we_b;
    logic [3:0]  be_a, be_b;
    logic [31:0] addr_a, addr_b, wd_a, wd_b;

    logic [31:0] o0_rd_a, o0_rd_b, o1_rd_a, o1_rd_b;
    logic        o0_rv_a, o0_rv_b, o0_er_a, o0_er_b, o0_col, o0_busy;
    logic        o1_rv_a, o1_rv_b, o1_er_a, o1_er_b, o1_col, o1_busy;

    always #5 clk = ~clk;

    dp_ram_be u0 (
        .clk(clk), .rst(rst), .clr(clr), .busy(o0_busy),
        .req_a(req_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .wd_a(wd_a),
        .rd_a(o0_rd_a), .rvalid_a(o0_rv_a), .err_a(o0_er_a),
        .req_b(req_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .wd_b(wd_b),
        .rd_b(o0_rd_b), .rvalid_b(o0_rv_b), .err_b(o0_er_b),
        .collision(o0_col)
    );

    dp_ram_be #(.OUT_REG(1), .RDW_FIRST(1)) u1 (
        .clk(clk), .rst(rst), .clr(clr), .busy(o1_busy),
        .req_a(req_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .wd_a(wd_a),
        .rd_a(o1_rd_a), .rvalid_a(o1_rv_a), .err_a(o1_er_a),
        .req_b(req_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .wd_b(wd_b),
        .rd_b(o1_rd_b), .rvalid_b(o1_rv_b), .err_b(o1_er_b),
        .collision(o1_col)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] rd_a, rd_b;
        logic        rv_a, rv_b, er_a, er_b, coll;
    } resp_t;

    logic [31:0] m_mem [256];
    bit          m_busy;
    int          m_cnt;
    logic [31:0] h0_a, h0_b, h1_a, h1_b;   // held rd values per instance
    resp_t       cur, prev;

    function automatic logic [31:0] put_bytes(input logic [31:0] w, input logic [31:0] d,
                                              input logic [3:0] be);
        logic [31:0] r;
        r = w;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_cnt = 0;
        h0_a = 0; h0_b = 0; h1_a = 0; h1_b = 0;
        prev = '{rd_a: 0, rd_b: 0, rv_a: 0, rv_b: 0, er_a: 0, er_b: 0, coll: 0};
    endtask

    task automatic model_edge();
        int ia, ib;
        bit ina, inb, acta, actb;
        logic [31:0] old_a, old_b;
        ia = int'(addr_a >> 2); ib = int'(addr_b >> 2);
        ina = ia < 256; inb = ib < 256;
        acta = req_a && !m_busy; actb = req_b && !m_busy;
        old_a = ina ? m_mem[ia] : 32'h0;
        old_b = inb ? m_mem[ib] : 32'h0;
        cur.rv_a = acta && !we_a;
        cur.rv_b = actb && !we_b;
        cur.er_a = req_a && (m_busy || !ina);
        cur.er_b = req_b && (m_busy || !inb);
        cur.coll = acta && actb && ina && inb && ia == ib && (we_a || we_b);
        if (acta && !we_a) begin h0_a = old_a; h1_a = old_a; end
        else if (acta && ina) begin h0_a = old_a; h1_a = put_bytes(old_a, wd_a, be_a); end
        if (actb && !we_b) begin h0_b = old_b; h1_b = old_b; end
        else if (actb && inb) begin h0_b = old_b; h1_b = put_bytes(old_b, wd_b, be_b); end
        cur.rd_a = h1_a; cur.rd_b = h1_b;
        if (m_busy) begin
            m_mem[m_cnt] = 0;
            m_cnt++;
            if (m_cnt == 256) m_busy = 0;
        end else begin
            if (actb && we_b && inb) m_mem[ib] = put_bytes(m_mem[ib], wd_b, be_b);
            if (acta && we_a && ina) m_mem[ia] = put_bytes(m_mem[ia], wd_a, be_a);
            if (clr) begin m_busy = 1; m_cnt = 0; end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("u0.rd_a", o0_rd_a, h0_a);      chk("u0.rd_b", o0_rd_b, h0_b);
        chk("u0.rv_a", 32'(o0_rv_a), 32'(cur.rv_a));
        chk("u0.rv_b", 32'(o0_rv_b), 32'(cur.rv_b));
        chk("u0.er_a", 32'(o0_er_a), 32'(cur.er_a));
        chk("u0.er_b", 32'(o0_er_b), 32'(cur.er_b));
        chk("u0.coll", 32'(o0_col), 32'(cur.coll));
        chk("u0.busy", 32'(o0_busy), 32'(m_busy));
        chk("u1.rd_a", o1_rd_a, prev.rd_a); chk("u1.rd_b", o1_rd_b, prev.rd_b);
        chk("u1.rv_a", 32'(o1_rv_a), 32'(prev.rv_a));
        chk("u1.rv_b", 32'(o1_rv_b), 32'(prev.rv_b));
        chk("u1.er_a", 32'(o1_er_a), 32'(prev.er_a));
        chk("u1.er_b", 32'(o1_er_b), 32'(prev.er_b));
        chk("u1.coll", 32'(o1_col), 32'(prev.coll));
        chk("u1.busy", 32'(o1_busy), 32'(m_busy));
        prev = cur;
    endtask

    task automatic drv(input bit ra, input bit wa, input logic [3:0] ba,
                       input logic [31:0] aa, input logic [31:0] da,
                       input bit rb, input bit wb, input logic [3:0] bb,
                       input logic [31:0] ab, input logic [31:0] db);
        req_a = ra; we_a = wa; be_a = ba; addr_a = aa; wd_a = da;
        req_b = rb; we_b = wb; be_b = bb; addr_b = ab; wd_b = db;
    endtask

    task automatic idle();
        drv(0, 0, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".rd_a0"}, o0_rd_a, 0); chk({tag, ".rd_b0"}, o0_rd_b, 0);
        chk({tag, ".rd_a1"}, o1_rd_a, 0); chk({tag, ".rd_b1"}, o1_rd_b, 0);
        chk({tag, ".flags0"}, 32'({o0_rv_a, o0_rv_b, o0_er_a, o0_er_b, o0_col, o0_busy}), 0);
        chk({tag, ".flags1"}, 32'({o1_rv_a, o1_rv_b, o1_er_a, o1_er_b, o1_col, o1_busy}), 0);
    endtask

    function automatic logic [31:0] rnd_addr();
        int w;
        int sel;
        sel = int'($urandom_range(0, 9));
        if (sel < 6)      w = int'($urandom_range(0, 7));
        else if (sel < 9) w = int'($urandom_range(0, 255));
        else              w = 256 + int'($urandom_range(0, 300));
        return 32'(w * 4 + int'($urandom_range(0, 3)));
    endfunction

    task automatic read_all();
        for (int w = 0; w < 256; w += 2) begin
            drv(1, 0, 4'h0, 32'(w * 4 + int'($urandom_range(0, 3))), 0,
                1, 0, 4'h0, 32'((w + 1) * 4), 0);
            step();
        end
        idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nbusy;
        for (int i = 0; i < 256; i++) m_mem[i] = 0;
        model_reset();
        cur = prev;
        rst = 1; clr = 0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 0;

        // full write then cross-port read
        drv(1, 1, 4'hF, 32'h10, 32'hDEADBEEF, 0, 0, 4'h0, 0, 0); step();
        drv(0, 0, 4'h0, 0, 0, 1, 0, 4'h0, 32'h10, 0);           step();
        chk("wr_rd.rd_b", o0_rd_b, 32'hDEADBEEF);
        chk("wr_rd.rv_b", 32'(o0_rv_b), 1);
        // partial byte write
        drv(1, 1, 4'b0010, 32'h10, 32'h0000AA00, 0, 0, 4'h0, 0, 0); step();
        drv(1, 0, 4'h0, 32'h13, 0, 0, 0, 4'h0, 0, 0);               step();
        chk("be.rd_a", o0_rd_a, 32'hDEADAAEF);
        // dual write to the same word
        drv(1, 1, 4'b0011, 32'h20, 32'h11111111, 1, 1, 4'b1111, 32'h20, 32'h22222222); step();
        chk("dual_wr.coll", 32'(o0_col), 1);
        drv(1, 0, 4'h0, 32'h20, 0, 0, 0, 4'h0, 0, 0); step();
        chk("dual_wr.rd_a", o0_rd_a, 32'h22221111);
        chk("dual_wr.coll_once", 32'(o0_col), 0);
        // both ports reading the same word
        drv(1, 0, 4'h0, 32'h20, 0, 1, 0, 4'h0, 32'h21, 0); step();
        chk("rr.coll", 32'(o0_col), 0);
        // out of range read and write
        drv(1, 0, 4'h0, 32'h400, 0, 0, 0, 4'h0, 0, 0); step();
        chk("oor_rd.rv", 32'(o0_rv_a), 1);
        chk("oor_rd.rd", o0_rd_a, 0);
        chk("oor_rd.err", 32'(o0_er_a), 1);
        drv(1, 1, 4'hF, 32'h400, 32'hFFFFFFFF, 0, 0, 4'h0, 0, 0); step();
        chk("oor_wr.err", 32'(o0_er_a), 1);
        drv(1, 0, 4'h0, 32'h0, 0, 0, 0, 4'h0, 0, 0); step();
        chk("oor_wr.mem0", o0_rd_a, 0);
        // same-port read-during-write, cross-port reader sees old data
        drv(1, 1, 4'hF, 32'h30, 32'h3, 0, 0, 4'h0, 0, 0); step();
        drv(1, 1, 4'hF, 32'h30, 32'h5, 1, 0, 4'h0, 32'h30, 0); step();
        chk("rdw.u0_old", o0_rd_a, 32'h3);
        chk("rdw.rd_b_old", o0_rd_b, 32'h3);
        chk("rdw.coll", 32'(o0_col), 1);
        idle(); step();
        chk("rdw.u1_new", o1_rd_a, 32'h5);
        chk("rdw.u1_coll", 32'(o1_col), 1);

        // clear: count busy cycles, requests during busy, clr while busy
        clr = 1; step(); clr = 0;
        nbusy = 0;
        while (o0_busy && nbusy < 400) begin
            nbusy++;
            clr = (nbusy == 50);
            drv(1, nbusy[0], 4'hF, rnd_addr(), $urandom(), 0, 0, 4'h0, 0, 0);
            step();
            if (nbusy == 10) begin
                chk("busy_rd.rv", 32'(o0_rv_a), 0);
                chk("busy_rd.err", 32'(o0_er_a), 1);
            end
        end
        clr = 0; idle();
        chk("clear.cycles", 32'(nbusy), 32'd256);
        for (int w = 0; w < 256; w++) begin
            drv(1, 0, 4'h0, 32'(w * 4), 0, 0, 0, 4'h0, 0, 0);
            step();
            chk("clear.zero", o0_rd_a, 0);
        end
        idle();

        // fill some words, start a clear, reset in the middle of it
        for (int i = 0; i < 64; i++) begin
            drv(1, 1, 4'hF, 32'(i * 16), $urandom(), 0, 0, 4'h0, 0, 0); step();
        end
        clr = 1; step(); clr = 0;
        repeat (37) begin
            drv(1, 0, 4'h0, rnd_addr(), 0, 1, 1, 4'hF, rnd_addr(), $urandom()); step();
        end
        idle();
        #2;
        rst = 1;
        #1;
        chk_all_zero("rst_mid_clear");
        model_reset();
        @(posedge clk); #1;
        rst = 0;
        read_all();

        // randomized traffic
        repeat (2000) begin
            clr = ($urandom_range(0, 599) == 0);
            drv($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 4'($urandom), rnd_addr(), $urandom(),
                $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 4'($urandom), rnd_addr(), $urandom());
            step();
        end
        clr = 0; idle();
        repeat (3) step();
        read_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
